// File: rtl/alu_result_fifo.sv
// First-word-fall-through FIFO for ALU results with op tag and flags.
// Add/sub entries also update sticky overflow/carry bits and an overflow counter.
module alu_result_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_op,
  input  logic [31:0]              in_result,
  input  logic [3:0]               in_flags,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2:0]               out_op,
  output logic [31:0]              out_result,
  output logic [3:0]               out_flags,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     sticky_v,
  output logic                     sticky_c,
  input  logic                     clr_sticky,
  output logic [7:0]               ovf_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);
  localparam int unsigned EntryW = 3 + 32 + 4;

  logic [EntryW-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              sticky_v_q, sticky_v_d;
  logic              sticky_c_q, sticky_c_d;
  logic [7:0]        ovf_cnt_q, ovf_cnt_d;

  logic push, pop, arith_push;

  // Ready comes from registered count only, so a full FIFO never accepts on a pop cycle.
  assign in_ready   = (count_q != FullCount);
  assign out_valid  = (count_q != '0);
  assign push       = in_valid & in_ready;
  assign pop        = out_valid & out_ready;
  assign arith_push = push & (in_op[2:1] == 2'b11);

  assign {out_op, out_result, out_flags} = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign sticky_v = sticky_v_q;
  assign sticky_c = sticky_c_q;
  assign ovf_cnt  = ovf_cnt_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    sticky_v_d = sticky_v_q;
    sticky_c_d = sticky_c_q;
    ovf_cnt_d  = ovf_cnt_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    unique case ({push, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase

    // Clear first so a same-cycle set takes priority.
    if (clr_sticky) begin
      sticky_v_d = 1'b0;
      sticky_c_d = 1'b0;
    end
    if (arith_push && in_flags[0]) sticky_v_d = 1'b1;
    if (arith_push && in_flags[3]) sticky_c_d = 1'b1;

    if (arith_push && in_flags[0] && (ovf_cnt_q != 8'hff)) ovf_cnt_d = ovf_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      sticky_v_q <= 1'b0;
      sticky_c_q <= 1'b0;
      ovf_cnt_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      sticky_v_q <= sticky_v_d;
      sticky_c_q <= sticky_c_d;
      ovf_cnt_q  <= ovf_cnt_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wr_ptr_q] <= {in_op, in_result, in_flags};
  end

endmodule

// File: tb/tb_alu_result_fifo.sv
// Randomised and directed checks of alu_result_fifo against a queue-based reference model.
module tb_alu_result_fifo;

  localparam int unsigned DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [31:0] in_result;
  logic [3:0]  in_flags;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_op;
  logic [31:0] out_result;
  logic [3:0]  out_flags;
  logic [2:0]  count;
  logic        sticky_v;
  logic        sticky_c;
  logic        clr_sticky;
  logic [7:0]  ovf_cnt;

  alu_result_fifo #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_result  (in_result),
    .in_flags   (in_flags),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_op     (out_op),
    .out_result (out_result),
    .out_flags  (out_flags),
    .count      (count),
    .sticky_v   (sticky_v),
    .sticky_c   (sticky_c),
    .clr_sticky (clr_sticky),
    .ovf_cnt    (ovf_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] res;
    logic [3:0]  fl;
  } ent_t;

  // Reference model: a queue plus sticky bits and a saturating counter.
  ent_t q[$];
  logic m_sv, m_sc;
  int   m_ovf;
  int   vectors, miscompares;
  logic last_push;

  // Drives one cycle of inputs and advances the model; ends at the following negedge.
  task automatic step(input logic r, input logic v, input logic [2:0] op, input logic [31:0] res,
                      input logic [3:0] fl, input logic ordy, input logic clr);
    logic do_push, do_pop;
    ent_t e;
    rst = r; in_valid = v; in_op = op; in_result = res; in_flags = fl;
    out_ready = ordy; clr_sticky = clr;
    do_push = v && (q.size() < DEPTH);
    do_pop  = ordy && (q.size() > 0);
    @(posedge clk);
    last_push = 1'b0;
    if (r) begin
      q.delete();
      m_sv = 1'b0; m_sc = 1'b0; m_ovf = 0;
    end else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        e.op = op; e.res = res; e.fl = fl;
        q.push_back(e);
        last_push = 1'b1;
      end
      if (clr) begin m_sv = 1'b0; m_sc = 1'b0; end
      if (do_push && (op == 3'd6 || op == 3'd7)) begin
        if (fl[0]) begin
          m_sv = 1'b1;
          if (m_ovf < 255) m_ovf = m_ovf + 1;
        end
        if (fl[3]) m_sc = 1'b1;
      end
    end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_sticky = 1'b0;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 3'd0, 32'd0, 4'd0, 1'b0, 1'b0);
    vectors++;
    if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_state: count=%0d out_valid=%b in_ready=%b, want 0/0/1",
               count, out_valid, in_ready);
    end
    vectors++;
    if (sticky_v !== 1'b0 || sticky_c !== 1'b0 || ovf_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_sticky: sv=%b sc=%b ovf=%0d, want 0/0/0", sticky_v, sticky_c, ovf_cnt);
    end
  endtask

  task automatic test_empty_push();
    step(1'b0, 1'b1, 3'b110, 32'h0000_0005, 4'b0000, 1'b0, 1'b0);
    vectors++;
    if (out_valid !== 1'b1 || out_result !== 32'd5 || count !== 3'd1 || out_op !== 3'b110) begin
      miscompares++;
      $display("FAIL empty_push: valid=%b result=%0h count=%0d op=%0d, want 1/5/1/6",
               out_valid, out_result, count, out_op);
    end
    step(1'b0, 1'b0, 3'd0, 32'd0, 4'd0, 1'b1, 1'b0);
    vectors++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL empty_drain: count=%0d valid=%b, want 0/0", count, out_valid);
    end
  endtask

  task automatic test_fill_overfill();
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 3'(i), 32'(10 + i), 4'(i), 1'b0, 1'b0);
      vectors++;
      if (count !== 3'(q.size()) || in_ready !== (q.size() < DEPTH)) begin
        miscompares++;
        $display("FAIL fill_%0d: count=%0d in_ready=%b, want %0d/%b", i, count, in_ready,
                 q.size(), q.size() < DEPTH);
      end
    end
    vectors++;
    if (count !== 3'd4 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL overfill: count=%0d in_ready=%b, want 4/0", count, in_ready);
    end
  endtask

  task automatic test_full_pop();
    vectors++;
    if (out_result !== 32'd10) begin
      miscompares++;
      $display("FAIL full_head: result=%0d, want 10", out_result);
    end
    step(1'b0, 1'b1, 3'd4, 32'd14, 4'd4, 1'b1, 1'b0);
    vectors++;
    if (count !== 3'd3 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL full_pop: count=%0d in_ready=%b, want 3/1", count, in_ready);
    end
    step(1'b0, 1'b1, 3'd4, 32'd14, 4'd4, 1'b0, 1'b0);
    vectors++;
    if (count !== 3'd4) begin
      miscompares++;
      $display("FAIL full_repush: count=%0d, want 4", count);
    end
    for (int i = 11; i <= 14; i++) begin
      vectors++;
      if (out_result !== 32'(i) || out_op !== q[0].op || out_flags !== q[0].fl) begin
        miscompares++;
        $display("FAIL drain_%0d: result=%0d op=%0d flags=%b, want %0d/%0d/%b", i, out_result,
                 out_op, out_flags, i, q[0].op, q[0].fl);
      end
      step(1'b0, 1'b0, 3'd0, 32'd0, 4'd0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_order_wrap();
    int next_push = 1;
    int exp_next  = 1;
    logic ordy    = 1'b0;
    int cycles    = 0;
    while (exp_next <= 10 && cycles < 100) begin
      if (ordy && out_valid) begin
        vectors++;
        if (out_result !== 32'(exp_next)) begin
          miscompares++;
          $display("FAIL order_%0d: result=%0d, want %0d", exp_next, out_result, exp_next);
        end
        exp_next++;
      end
      step(1'b0, next_push <= 10, 3'd1, 32'(next_push), 4'd0, ordy, 1'b0);
      if (last_push) next_push++;
      ordy = ~ordy;
      cycles++;
    end
    vectors++;
    if (exp_next != 11) begin
      miscompares++;
      $display("FAIL order_timeout: popped %0d, want 10", exp_next - 1);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 49) == 0), $urandom_range(0, 1), 3'($urandom), $urandom,
           4'($urandom), $urandom_range(0, 1), ($urandom_range(0, 7) == 0));
      vectors++;
      if (count !== 3'(q.size()) || out_valid !== (q.size() > 0) ||
          in_ready !== (q.size() < DEPTH) || sticky_v !== m_sv || sticky_c !== m_sc ||
          ovf_cnt !== 8'(m_ovf)) begin
        miscompares++;
        $display("FAIL random_state_%0d: cnt=%0d v=%b r=%b sv=%b sc=%b ovf=%0d, want %0d/%b/%b/%b/%b/%0d",
                 i, count, out_valid, in_ready, sticky_v, sticky_c, ovf_cnt, q.size(),
                 q.size() > 0, q.size() < DEPTH, m_sv, m_sc, m_ovf);
      end
      if (q.size() > 0) begin
        vectors++;
        if ({out_op, out_result, out_flags} !== q[0]) begin
          miscompares++;
          $display("FAIL random_head_%0d: got %0h, want %0h", i, {out_op, out_result, out_flags},
                   q[0]);
        end
      end
    end
  endtask

  task automatic test_sticky_sat();
    step(1'b1, 1'b0, 3'd0, 32'd0, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) step(1'b0, 1'b1, 3'b111, 32'(i), 4'b1001, 1'b1, 1'b0);
    vectors++;
    if (sticky_v !== 1'b1 || sticky_c !== 1'b1 || ovf_cnt !== 8'd255) begin
      miscompares++;
      $display("FAIL saturate: sv=%b sc=%b ovf=%0d, want 1/1/255", sticky_v, sticky_c, ovf_cnt);
    end
    step(1'b0, 1'b1, 3'b111, 32'd1, 4'b0000, 1'b1, 1'b1);
    vectors++;
    if (sticky_v !== 1'b0 || sticky_c !== 1'b0 || ovf_cnt !== 8'd255) begin
      miscompares++;
      $display("FAIL clr_sticky: sv=%b sc=%b ovf=%0d, want 0/0/255", sticky_v, sticky_c, ovf_cnt);
    end
    step(1'b0, 1'b1, 3'b101, 32'd2, 4'b1111, 1'b1, 1'b0);
    vectors++;
    if (sticky_v !== 1'b0 || sticky_c !== 1'b0 || out_flags !== 4'b1111) begin
      miscompares++;
      $display("FAIL non_arith: sv=%b sc=%b flags=%b, want 0/0/1111", sticky_v, sticky_c,
               out_flags);
    end
    step(1'b0, 1'b1, 3'b110, 32'd3, 4'b1001, 1'b1, 1'b1);
    vectors++;
    if (sticky_v !== 1'b1 || sticky_c !== 1'b1) begin
      miscompares++;
      $display("FAIL set_wins: sv=%b sc=%b, want 1/1", sticky_v, sticky_c);
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 1'b0, 3'd0, 32'd0, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 3'b110, 32'(i), 4'b0001, 1'b0, 1'b0);
    vectors++;
    if (count !== 3'd3 || ovf_cnt !== 8'd3) begin
      miscompares++;
      $display("FAIL mid_prefill: count=%0d ovf=%0d, want 3/3", count, ovf_cnt);
    end
    step(1'b1, 1'b1, 3'b111, 32'd9, 4'b1001, 1'b1, 1'b0);
    vectors++;
    if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || ovf_cnt !== 8'd0 ||
        sticky_v !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset: count=%0d valid=%b ready=%b ovf=%0d sv=%b, want 0/0/1/0/0",
               count, out_valid, in_ready, ovf_cnt, sticky_v);
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    m_sv = 1'b0; m_sc = 1'b0; m_ovf = 0; last_push = 1'b0;
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_result = '0; in_flags = '0;
    out_ready = 1'b0; clr_sticky = 1'b0;
    @(negedge clk);
    test_reset();
    test_empty_push();
    test_fill_overfill();
    test_full_pop();
    test_order_wrap();
    test_random();
    test_sticky_sat();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
